firebird_dmem: RTL and testbench



---
 rtl/firebird_pkg.sv | 38 +++
 rtl/firebird_dmem_lane.sv | 75 +++++++
 rtl/firebird_dmem.sv | 204 ++++++++++++++++++++
 tb/tb_firebird_dmem.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/firebird_pkg.sv
// Shared Firebird definitions: funct3 size codes, the opcode constants used by
// the control unit, and the data-memory FSM state encoding.
package firebird_pkg;

    // Load/store access size and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Major opcodes decoded by the control unit
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Data-memory responder states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // True when funct3 names a real RV32I access of the given direction
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/firebird_dmem_lane.sv
// Byte-lane steering for the data memory: store byte enables and aligned
// write data, load lane extraction with sign/zero extension, and the
// misalignment flag for half and word accesses.
import firebird_pkg::*;

module firebird_dmem_lane (
    input  logic [1:0]  byte_sel,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Store path: replicate the source into every lane and enable only the target bytes
    always_comb begin
        be       = 4'b0000;
        wdata_al = wdata;
        case (funct3[1:0])
            2'b00: begin
                be       = 4'b0001 << byte_sel;
                wdata_al = {4{wdata[7:0]}};
            end
            2'b01: begin
                be       = byte_sel[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
            end
            2'b10: begin
                be       = 4'b1111;
                wdata_al = wdata;
            end
            default: begin
                be       = 4'b0000;
                wdata_al = wdata;
            end
        endcase
    end

    // Load path: pick the addressed byte/half and extend it to 32 bits
    always_comb begin
        sel_byte  = rword[7:0];
        case (byte_sel)
            2'd0:    sel_byte = rword[7:0];
            2'd1:    sel_byte = rword[15:8];
            2'd2:    sel_byte = rword[23:16];
            default: sel_byte = rword[31:24];
        endcase
        sel_half  = byte_sel[1] ? rword[31:16] : rword[15:0];
        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = rword;
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = 32'd0;
        endcase
    end

    // Half accesses need an even address, word accesses a multiple of four
    always_comb begin
        misalign = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            misalign = byte_sel[0];
        end else if (funct3[1:0] == 2'b10) begin
            misalign = (byte_sel != 2'b00);
        end
    end

endmodule

// File: rtl/firebird_dmem.sv
// Firebird data-memory responder. Accepts one load or store at a time, waits
// LATENCY cycles, then returns a single-cycle response.
// Optional console register: define FIREBIRD_DMEM_MMIO_EN to add the
// mmio_valid/mmio_data outputs and decode stores to MMIO_ADDR.
//
// Handshake: a request is taken on any rising edge where req_ready=1 and
// mem_read|mem_write=1; req_ready is high only in IDLE and strobes seen
// elsewhere are dropped. resp_valid is a one-cycle pulse with no
// backpressure; resp_err and rdata are meaningful while it is high, and
// rdata keeps the last response value until the next one.
import firebird_pkg::*;

module firebird_dmem #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] MMIO_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic        req_ready,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        resp_err,
`ifdef FIREBIRD_DMEM_MMIO_EN
    output logic        mmio_valid,
    output logic [7:0]  mmio_data,
`endif
    output logic        busy
);

    localparam int         IDXW   = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        rd_q, wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  f3_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        mmio_st_q;

    logic [31:0] mem [DEPTH];

    logic        accept, enter_resp;
    logic        cur_rd, cur_wr;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_f3;
    logic [IDXW-1:0] idx;
    logic        both, f3_ok, range_bad, misalign, mmio_hit, err, do_write;
    logic [3:0]  be;
    logic [31:0] wdata_al, load_data;

    assign accept     = (state_q == IDLE) && (mem_read || mem_write);
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign rdata      = rdata_q;

    // State and wait counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: IDLE -> WAIT (LATENCY cycles) -> RESP (one cycle) -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero latency the commit edge is the accept edge, so decode from the live inputs then
    always_comb begin
        if (state_q == IDLE) begin
            cur_rd    = mem_read;
            cur_wr    = mem_write;
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_f3    = funct3;
        end else begin
            cur_rd    = rd_q;
            cur_wr    = wr_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_f3    = f3_q;
        end
    end

    assign idx        = cur_addr[IDXW+1:2];
    assign enter_resp = (state_d == RESP) && (state_q != RESP) && !rst;

    firebird_dmem_lane u_lane (
        .byte_sel  (cur_addr[1:0]),
        .funct3    (cur_f3),
        .wdata     (cur_wdata),
        .rword     (mem[idx]),
        .be        (be),
        .wdata_al  (wdata_al),
        .load_data (load_data),
        .misalign  (misalign)
    );

    // Fault and console decode for the request being committed
    always_comb begin
        both      = cur_rd && cur_wr;
        f3_ok     = f3_legal(cur_wr, cur_f3);
        range_bad = (cur_addr[31:2] >= 30'(DEPTH));
`ifdef FIREBIRD_DMEM_MMIO_EN
        mmio_hit  = !both && (cur_addr == MMIO_ADDR);
`else
        mmio_hit  = 1'b0;
`endif
        err       = !mmio_hit && (both || !f3_ok || misalign || range_bad);
        do_write  = enter_resp && cur_wr && !err && !mmio_hit;
    end

    // Request latch and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            f3_q      <= 3'd0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            mmio_st_q <= 1'b0;
        end else begin
            if (accept) begin
                rd_q    <= mem_read;
                wr_q    <= mem_write;
                addr_q  <= addr;
                wdata_q <= wdata;
                f3_q    <= funct3;
            end
            if (enter_resp) begin
                err_q     <= err;
                rdata_q   <= (cur_rd && !cur_wr && !err && !mmio_hit) ? load_data : 32'd0;
                mmio_st_q <= mmio_hit && cur_wr;
            end
        end
    end

    // Array write with per-byte enables on the edge entering RESP
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
                end
            end
        end
    end

`ifdef FIREBIRD_DMEM_MMIO_EN
    logic [7:0] mmio_data_q;

    // Console byte captured when a store to the console register commits
    always_ff @(posedge clk) begin
        if (rst) begin
            mmio_data_q <= 8'd0;
        end else if (enter_resp && mmio_hit && cur_wr) begin
            mmio_data_q <= cur_wdata[7:0];
        end
    end

    assign mmio_valid = (state_q == RESP) && mmio_st_q;
    assign mmio_data  = mmio_data_q;
`endif

endmodule

// File: tb/tb_firebird_dmem.sv
// Self-checking bench for firebird_dmem: directed load/store cases, fault
// cases, held strobes, reset mid-request, then randomized traffic compared
// against a byte-addressed reference model.
// Build with FIREBIRD_DMEM_MMIO_EN defined to exercise the console register.
module tb_firebird_dmem;

    localparam int          DEPTH     = 1024;
    localparam int          LATENCY   = 2;
    localparam logic [31:0] MMIO_ADDR = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        req_ready;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        resp_err;
    logic        busy;
`ifdef FIREBIRD_DMEM_MMIO_EN
    logic        mmio_valid;
    logic [7:0]  mmio_data;
`endif

    int total;
    int bad;

    // reference memory, one entry per byte address
    logic [7:0] mb [logic [31:0]];
    // expected results of the transaction in flight
    logic [31:0] exp_q[$];

    firebird_dmem #(
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY),
        .MMIO_ADDR (MMIO_ADDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .funct3     (funct3),
        .req_ready  (req_ready),
        .rdata      (rdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
`ifdef FIREBIRD_DMEM_MMIO_EN
        .mmio_valid (mmio_valid),
        .mmio_data  (mmio_data),
`endif
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    // Reference: decide the outcome from the access rules, update the byte memory
    function automatic void model(input bit rd, input bit wr, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] f3,
                                  output bit err, output logic [31:0] rv, output bit mv);
        int size;
        bit legal;
        bit hit;
        logic [31:0] v;
        err  = 1'b0;
        rv   = 32'd0;
        mv   = 1'b0;
        hit  = 1'b0;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = wr ? (f3 <= 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef FIREBIRD_DMEM_MMIO_EN
        hit = !(rd && wr) && (a == MMIO_ADDR);
`endif
        if (hit) begin
            mv = wr;
            return;
        end
        if ((rd && wr) || !legal || (a % size) != 0 || (a >> 2) >= DEPTH) begin
            err = 1'b1;
            return;
        end
        if (wr) begin
            for (int i = 0; i < size; i++) mb[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mb[a + i];
            if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            rv = v;
        end
    endfunction

    // driver: one complete request; hold=1 keeps a different store strobed during the wait
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3, input bit hold);
        int cyc;
        bit e;
        bit mv;
        logic [31:0] rv;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        funct3    = f3;
        @(posedge clk); #1;
        if (hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b1;
            addr      = a + 32'd4;
            wdata     = ~wd;
            funct3    = 3'b010;
        end else begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        model(rd, wr, a, wd, f3, e, rv, mv);
        exp_q.push_back(rv);
        // cycles counted from the accept cycle
        cyc = 1;
        while (!resp_valid && cyc < 50) begin
            if (hold) chk("ready_in_wait", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1; cyc++;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk("latency", cyc, LATENCY + 1);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e});
        rv = exp_q.pop_front();
        chk("rdata", rdata, rv);
`ifdef FIREBIRD_DMEM_MMIO_EN
        chk("mmio_valid", {31'd0, mmio_valid}, {31'd0, mv});
        if (mv) chk("mmio_data", {24'd0, mmio_data}, {24'd0, wd[7:0]});
`endif
        @(posedge clk); #1;
        chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
        chk("rdata_hold", rdata, rv);
        chk("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int n_resp;
        logic [31:0] ra;
        logic [2:0]  rf;
        bit rr, rw;
        int r;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        funct3    = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef FIREBIRD_DMEM_MMIO_EN
        chk("rst_mmio_valid", {31'd0, mmio_valid}, 32'd0);
        chk("rst_mmio_data", {24'd0, mmio_data}, 32'd0);
`endif
        rst = 1'b0;

        // preload the working region 0x00..0x3F
        for (int w = 0; w < 16; w++) do_req(1'b0, 1'b1, 32'(w * 4), $urandom, 3'b010, 1'b0);
        do_req(1'b0, 1'b1, 32'h20, 32'h0, 3'b010, 1'b0);

        // directed loads/stores
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        chk("plan_lw", rdata, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h13, 32'h0, 3'b000, 1'b0);
        chk("plan_lb", rdata, 32'hFFFFFFDE);
        do_req(1'b1, 1'b0, 32'h13, 32'h0, 3'b100, 1'b0);
        chk("plan_lbu", rdata, 32'h000000DE);
        do_req(1'b1, 1'b0, 32'h12, 32'h0, 3'b001, 1'b0);
        chk("plan_lh", rdata, 32'hFFFFDEAD);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b101, 1'b0);
        chk("plan_lhu", rdata, 32'h0000BEEF);
        do_req(1'b0, 1'b1, 32'h11, 32'h55, 3'b000, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        chk("plan_sb", rdata, 32'hDEAD55EF);
        do_req(1'b0, 1'b1, 32'h12, 32'h1234, 3'b001, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        chk("plan_sh", rdata, 32'h123455EF);

        // faults
        do_req(1'b1, 1'b0, 32'h11, 32'h0, 3'b010, 1'b0);
        do_req(1'b0, 1'b1, 32'h13, 32'hFFFF, 3'b001, 1'b0);
        do_req(1'b1, 1'b0, 32'h1000, 32'h0, 3'b010, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 1'b0);
        do_req(1'b1, 1'b1, 32'h10, 32'h0, 3'b010, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        chk("plan_after_err", rdata, 32'h123455EF);

        // strobe held through the wait must be ignored
        do_req(1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 3'b010, 1'b1);
        do_req(1'b1, 1'b0, 32'h28, 32'h0, 3'b010, 1'b0);
        do_req(1'b1, 1'b0, 32'h24, 32'h0, 3'b010, 1'b0);
        chk("plan_hold", rdata, 32'hCAFEF00D);

        // reset during the wait of SW 0x20 = 1
        mem_write = 1'b1;
        addr      = 32'h20;
        wdata     = 32'h1;
        funct3    = 3'b010;
        @(posedge clk); #1;
        mem_write = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_resp = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) n_resp++;
            @(posedge clk); #1;
        end
        chk("rst_no_resp", n_resp, 0);
        chk("rst_mid_idle", {31'd0, busy}, 32'd0);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0);
        chk("plan_rst_store", rdata, 32'h0);

        // console store
        do_req(1'b0, 1'b1, MMIO_ADDR, 32'h41, 3'b000, 1'b0);

        // randomized traffic
        for (int t = 0; t < 200; t++) begin
            r  = int'($urandom_range(0, 15));
            rr = (r == 0) || (r < 8);
            rw = (r == 0) || (r >= 8);
            r  = int'($urandom_range(0, 15));
            if (r == 0)      ra = 32'h1000 + 32'($urandom_range(0, 255));
            else if (r == 1) ra = MMIO_ADDR;
            else             ra = 32'($urandom_range(0, 63));
            r  = int'($urandom_range(0, 9));
            if (r < 2) begin
                rf = 3'($urandom_range(0, 7));
            end else begin
                r  = int'($urandom_range(0, 4));
                rf = (r == 3) ? 3'b100 : (r == 4) ? 3'b101 : 3'(r);
            end
            if (rf[1:0] == 2'b01 && $urandom_range(0, 3) != 0) ra[0] = 1'b0;
            if (rf[1:0] == 2'b10 && $urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            do_req(rr, rw, ra, $urandom, rf, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
